// File: rtl/serial_compare_word_sequencer.sv
// serial_compare_word_sequencer
// Takes one pair of WIDTH-bit words over a valid/ready handshake and clears an
// external MSB-first serial comparator. It then feeds the pair to the
// comparator one bit per cycle and returns the captured less/eq/greater flags
// as a single result. Only one word pair is in flight at a time.
// Every output is driven straight from a flop.

module serial_compare_word_sequencer #(
    parameter int WIDTH       = 8,
    parameter int CMP_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clear,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             cmp_less,
    input  logic             cmp_eq,
    input  logic             cmp_greater,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_less,
    output logic             out_eq,
    output logic             out_greater,
    output logic             out_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SHIFT  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_ser_clear;
    logic             r_ser_valid;
    logic             r_ser_a;
    logic             r_ser_b;
    logic             r_out_valid;
    logic             r_out_less;
    logic             r_out_eq;
    logic             r_out_greater;
    logic             r_out_err;

    // A well-formed comparator drives exactly one of its three flags.
    function automatic logic f_not_onehot(input logic l, input logic e, input logic g);
        logic v;
        case ({l, e, g})
            3'b100, 3'b010, 3'b001: v = 1'b0;
            default:                v = 1'b1;
        endcase
        return v;
    endfunction

    // Sequencer FSM: the state and every registered output move together here.
    // The serial bit registers are loaded one edge ahead. The bit shown in a
    // SHIFT cycle was shifted out of r_sh_* on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sh_a        <= {WIDTH{1'b0}};
            r_sh_b        <= {WIDTH{1'b0}};
            r_cnt         <= {CW{1'b0}};
            r_in_ready    <= 1'b1;
            r_ser_clear   <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_ser_a       <= 1'b0;
            r_ser_b       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_less    <= 1'b0;
            r_out_eq      <= 1'b0;
            r_out_greater <= 1'b0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sh_a      <= in_a;
                        r_sh_b      <= in_b;
                        r_in_ready  <= 1'b0;
                        r_ser_clear <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_ser_clear <= 1'b0;
                    r_cnt       <= CW'(WIDTH - 1);
                    r_ser_valid <= 1'b1;
                    r_ser_a     <= r_sh_a[WIDTH-1];
                    r_ser_b     <= r_sh_b[WIDTH-1];
                    r_sh_a      <= {r_sh_a[WIDTH-2:0], 1'b0};
                    r_sh_b      <= {r_sh_b[WIDTH-2:0], 1'b0};
                    r_state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt != {CW{1'b0}}) begin
                        r_cnt   <= r_cnt - CW'(1);
                        r_ser_a <= r_sh_a[WIDTH-1];
                        r_ser_b <= r_sh_b[WIDTH-1];
                        r_sh_a  <= {r_sh_a[WIDTH-2:0], 1'b0};
                        r_sh_b  <= {r_sh_b[WIDTH-2:0], 1'b0};
                    end else begin
                        r_ser_valid <= 1'b0;
                        r_ser_a     <= 1'b0;
                        r_ser_b     <= 1'b0;
                        if (CMP_LATENCY == 0) begin
                            // The combinational comparator already reflects the last bit.
                            r_out_less    <= cmp_less;
                            r_out_eq      <= cmp_eq;
                            r_out_greater <= cmp_greater;
                            r_out_err     <= f_not_onehot(cmp_less, cmp_eq, cmp_greater);
                            r_out_valid   <= 1'b1;
                            r_state       <= S_RESULT;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_out_less    <= cmp_less;
                    r_out_eq      <= cmp_eq;
                    r_out_greater <= cmp_greater;
                    r_out_err     <= f_not_onehot(cmp_less, cmp_eq, cmp_greater);
                    r_out_valid   <= 1'b1;
                    r_state       <= S_RESULT;
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_ser_clear <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_a     <= 1'b0;
                    r_ser_b     <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign ser_clear   = r_ser_clear;
    assign ser_valid   = r_ser_valid;
    assign ser_a       = r_ser_a;
    assign ser_b       = r_ser_b;
    assign out_valid   = r_out_valid;
    assign out_less    = r_out_less;
    assign out_eq      = r_out_eq;
    assign out_greater = r_out_greater;
    assign out_err     = r_out_err;

endmodule

// File: tb/tb_serial_compare_word_sequencer.sv
// Bench for serial_compare_word_sequencer. It uses two instances.
// dut1 has CMP_LATENCY=1 and is driven by a registered comparator model.
// dut0 has CMP_LATENCY=0 and is driven by a combinational comparator model.
// Expected results are computed from the operands when a pair is accepted.
// They are pushed to a per-instance queue and popped when out_valid is seen.

module tb_serial_compare_word_sequencer;

    localparam int W = 8;

    typedef struct packed {
        logic l;
        logic e;
        logic g;
        logic err;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    res_t q1[$];
    res_t q0[$];

    // dut1 (registered comparator)
    logic         v1, rdy1, clr1, sv1, sa1, sb1, c1l, c1e, c1g;
    logic         ov1, ordy1, ol1, oe1, og1, oerr1;
    logic [W-1:0] a1, b1;
    // dut0 (combinational comparator)
    logic         v0, rdy0, clr0, sv0, sa0, sb0, c0l, c0e, c0g;
    logic         ov0, ordy0, ol0, oe0, og0, oerr0;
    logic [W-1:0] a0, b0;
    logic         force0;

    serial_compare_word_sequencer #(.WIDTH(W), .CMP_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
        .ser_clear(clr1), .ser_valid(sv1), .ser_a(sa1), .ser_b(sb1),
        .cmp_less(c1l), .cmp_eq(c1e), .cmp_greater(c1g),
        .out_valid(ov1), .out_ready(ordy1), .out_less(ol1), .out_eq(oe1),
        .out_greater(og1), .out_err(oerr1)
    );

    serial_compare_word_sequencer #(.WIDTH(W), .CMP_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
        .ser_clear(clr0), .ser_valid(sv0), .ser_a(sa0), .ser_b(sb0),
        .cmp_less(c0l), .cmp_eq(c0e), .cmp_greater(c0g),
        .out_valid(ov0), .out_ready(ordy0), .out_less(ol0), .out_eq(oe0),
        .out_greater(og0), .out_err(oerr0)
    );

    // Registered MSB-first comparator model: the first differing bit decides.
    logic m1_lt, m1_gt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_lt <= 1'b0; m1_gt <= 1'b0;
        end else if (clr1) begin
            m1_lt <= 1'b0; m1_gt <= 1'b0;
        end else if (sv1 && !m1_lt && !m1_gt) begin
            m1_lt <= !sa1 && sb1; m1_gt <= sa1 && !sb1;
        end
    end
    assign c1l = m1_lt;
    assign c1g = m1_gt;
    assign c1e = !m1_lt && !m1_gt;

    // Combinational comparator model: decision state plus the live bit.
    logic m0_lt, m0_gt, w0_lt, w0_gt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_lt <= 1'b0; m0_gt <= 1'b0;
        end else if (clr0) begin
            m0_lt <= 1'b0; m0_gt <= 1'b0;
        end else begin
            m0_lt <= w0_lt; m0_gt <= w0_gt;
        end
    end
    // Merge the live bit into the decision when it is still open.
    always_comb begin
        w0_lt = m0_lt;
        w0_gt = m0_gt;
        if (sv0 && !m0_lt && !m0_gt) begin
            w0_lt = !sa0 && sb0;
            w0_gt = sa0 && !sb0;
        end
    end
    assign c0l = force0 ? 1'b1 : w0_lt;
    assign c0e = force0 ? 1'b1 : (!w0_lt && !w0_gt);
    assign c0g = force0 ? 1'b0 : w0_gt;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t pop1();
        if (q1.size() == 0) return 4'bxxxx;
        return q1.pop_front();
    endfunction

    function automatic res_t pop0();
        if (q0.size() == 0) return 4'bxxxx;
        return q0.pop_front();
    endfunction

    // Drive a pair into dut1 from a negedge and push its expected result at the accept edge.
    task automatic accept1(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t e;
        e.l = (a < b); e.e = (a == b); e.g = (a > b); e.err = 1'b0;
        a1 = a; b1 = b; v1 = 1'b1;
        @(posedge clk);
        q1.push_back(e);
        #1 v1 = 1'b0;
    endtask

    task automatic accept0(input logic [W-1:0] a, input logic [W-1:0] b, input logic forced);
        res_t e;
        e.l = (a < b); e.e = (a == b); e.g = (a > b); e.err = 1'b0;
        if (forced) e = 4'b1101;
        a0 = a; b0 = b; v0 = 1'b1;
        @(posedge clk);
        q0.push_back(e);
        #1 v0 = 1'b0;
    endtask

    // Count negedges until out_valid. Returns -1 if the bound expires.
    task automatic wait_ov1(input int start, output int cyc);
        cyc = start;
        while (ov1 !== 1'b1) begin
            if (cyc >= start + 40) begin cyc = -1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_ov0(input int start, output int cyc);
        cyc = start;
        while (ov0 !== 1'b1) begin
            if (cyc >= start + 40) begin cyc = -1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy1, clr1, sv1, sa1, sb1, ov1, ol1, oe1, og1, oerr1} !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_dut1: got %b expected %b",
                     {rdy1, clr1, sv1, sa1, sb1, ov1, ol1, oe1, og1, oerr1}, 10'b1000000000);
        end
        checks++;
        if ({rdy0, clr0, sv0, sa0, sb0, ov0, ol0, oe0, og0, oerr0} !== 10'b1000000000) begin
            errors++;
            $display("FAIL reset_dut0: got %b expected %b",
                     {rdy0, clr0, sv0, sa0, sb0, ov0, ol0, oe0, og0, oerr0}, 10'b1000000000);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_equal_trace();
        logic [W-1:0] a;
        logic         be;
        res_t         e;
        a = 8'hA5;
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1) begin errors++; $display("FAIL eq_in_ready: got %b expected 1", rdy1); end
        accept1(a, a);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            be = (cyc >= 2 && cyc <= 9) ? a[W + 1 - cyc] : 1'b0;
            checks++;
            if (clr1 !== (cyc == 1)) begin
                errors++; $display("FAIL eq_ser_clear c%0d: got %b expected %b", cyc, clr1, (cyc == 1));
            end
            checks++;
            if (sv1 !== (cyc >= 2 && cyc <= 9)) begin
                errors++; $display("FAIL eq_ser_valid c%0d: got %b expected %b", cyc, sv1, (cyc >= 2 && cyc <= 9));
            end
            checks++;
            if ({sa1, sb1} !== {be, be}) begin
                errors++; $display("FAIL eq_ser_bits c%0d: got %b expected %b", cyc, {sa1, sb1}, {be, be});
            end
            checks++;
            if (ov1 !== (cyc == 11)) begin
                errors++; $display("FAIL eq_out_valid c%0d: got %b expected %b", cyc, ov1, (cyc == 11));
            end
        end
        e = pop1();
        checks++;
        if ({ol1, oe1, og1, oerr1} !== e) begin
            errors++; $display("FAIL eq_result: got %b expected %b", {ol1, oe1, og1, oerr1}, e);
        end
        ordy1 = 1'b1;
        @(posedge clk);
        #1 ordy1 = 1'b0;
    endtask

    task automatic test_greater();
        int   cyc;
        res_t e;
        @(negedge clk);
        accept1(8'h80, 8'h7F);
        repeat (2) @(negedge clk);
        checks++;
        if ({sv1, sa1, sb1} !== 3'b110) begin
            errors++; $display("FAIL gt_first_bits: got %b expected 110", {sv1, sa1, sb1});
        end
        wait_ov1(2, cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL gt_latency: got %0d expected 11", cyc); end
        e = pop1();
        checks++;
        if ({ol1, oe1, og1, oerr1} !== e) begin
            errors++; $display("FAIL gt_result: got %b expected %b", {ol1, oe1, og1, oerr1}, e);
        end
        ordy1 = 1'b1;
        @(posedge clk);
        #1 ordy1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   cyc;
        res_t e;
        ordy1 = 1'b1;
        @(negedge clk);
        accept1(8'h00, 8'hFF);
        wait_ov1(0, cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL b2b_latency1: got %0d expected 11", cyc); end
        e = pop1();
        checks++;
        if ({ol1, oe1, og1, oerr1} !== e) begin
            errors++; $display("FAIL b2b_result1: got %b expected %b", {ol1, oe1, og1, oerr1}, e);
        end
        a1 = 8'h3C; b1 = 8'h3C; v1 = 1'b1;
        checks++;
        if (rdy1 !== 1'b0) begin errors++; $display("FAIL b2b_ready_c11: got %b expected 0", rdy1); end
        @(negedge clk);
        checks++;
        if ({rdy1, ov1} !== 2'b10) begin
            errors++; $display("FAIL b2b_ready_c12: got %b expected 10", {rdy1, ov1});
        end
        @(posedge clk);
        e.l = 1'b0; e.e = 1'b1; e.g = 1'b0; e.err = 1'b0;
        q1.push_back(e);
        #1 v1 = 1'b0;
        @(negedge clk);
        checks++;
        if (clr1 !== 1'b1) begin errors++; $display("FAIL b2b_clear_c13: got %b expected 1", clr1); end
        wait_ov1(1, cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL b2b_latency2: got %0d expected 11", cyc); end
        e = pop1();
        checks++;
        if ({ol1, oe1, og1, oerr1} !== e) begin
            errors++; $display("FAIL b2b_result2: got %b expected %b", {ol1, oe1, og1, oerr1}, e);
        end
        @(posedge clk);
        #1 ordy1 = 1'b0;
    endtask

    task automatic test_hold_result();
        int   cyc;
        res_t e;
        ordy1 = 1'b0;
        @(negedge clk);
        accept1(8'h55, 8'h33);
        wait_ov1(0, cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL hold_latency: got %0d expected 11", cyc); end
        e = pop1();
        for (int i = 0; i < 5; i++) begin
            v1 = i[0] ? 1'b0 : 1'b1;
            a1 = W'($urandom);
            b1 = W'($urandom);
            @(negedge clk);
            checks++;
            if ({ov1, rdy1, clr1, ol1, oe1, og1, oerr1} !== {3'b100, e}) begin
                errors++; $display("FAIL hold_stable i%0d: got %b expected %b",
                                   i, {ov1, rdy1, clr1, ol1, oe1, og1, oerr1}, {3'b100, e});
            end
        end
        v1 = 1'b0;
        ordy1 = 1'b1;
        @(posedge clk);
        #1 ordy1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy1, ov1, ol1, oe1, og1, oerr1} !== {2'b10, e}) begin
            errors++; $display("FAIL hold_release: got %b expected %b", {rdy1, ov1, ol1, oe1, og1, oerr1}, {2'b10, e});
        end
        @(negedge clk);
        checks++;
        if ({rdy1, clr1, sv1} !== 3'b100) begin
            errors++; $display("FAIL hold_no_accept: got %b expected 100", {rdy1, clr1, sv1});
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        res_t e;
        @(negedge clk);
        accept1(8'hC3, 8'h3C);
        repeat (5) @(negedge clk);
        checks++;
        if (sv1 !== 1'b1) begin errors++; $display("FAIL rstmid_in_shift: got %b expected 1", sv1); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sv1, sa1, sb1, rdy1, ov1, clr1} !== 6'b000100) begin
            errors++; $display("FAIL rstmid_async: got %b expected 000100", {sv1, sa1, sb1, rdy1, ov1, clr1});
        end
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        accept1(8'h12, 8'h34);
        wait_ov1(0, cyc);
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL rstmid_latency: got %0d expected 11", cyc); end
        e = pop1();
        checks++;
        if ({ol1, oe1, og1, oerr1} !== e) begin
            errors++; $display("FAIL rstmid_result: got %b expected %b", {ol1, oe1, og1, oerr1}, e);
        end
        ordy1 = 1'b1;
        @(posedge clk);
        #1 ordy1 = 1'b0;
    endtask

    task automatic test_comb_latency();
        int   cyc;
        res_t e;
        ordy0 = 1'b0;
        @(negedge clk);
        accept0(8'h5A, 8'h5A, 1'b0);
        wait_ov0(0, cyc);
        checks++;
        if (cyc != 10) begin errors++; $display("FAIL comb_latency: got %0d expected 10", cyc); end
        e = pop0();
        checks++;
        if ({ol0, oe0, og0, oerr0} !== e) begin
            errors++; $display("FAIL comb_result: got %b expected %b", {ol0, oe0, og0, oerr0}, e);
        end
        ordy0 = 1'b1;
        @(posedge clk);
        #1 ordy0 = 1'b0;
        @(negedge clk);
        accept0(8'h20, 8'h10, 1'b1);
        repeat (9) @(negedge clk);
        checks++;
        if ({sv0, ov0} !== 2'b10) begin
            errors++; $display("FAIL comb_capture_cycle: got %b expected 10", {sv0, ov0});
        end
        force0 = 1'b1;
        @(posedge clk);
        #1 force0 = 1'b0;
        @(negedge clk);
        e = pop0();
        checks++;
        if ({ov0, ol0, oe0, og0, oerr0} !== {1'b1, e}) begin
            errors++; $display("FAIL comb_err_flags: got %b expected %b", {ov0, ol0, oe0, og0, oerr0}, {1'b1, e});
        end
        ordy0 = 1'b1;
        @(posedge clk);
        #1 ordy0 = 1'b0;
    endtask

    initial begin
        v1 = 1'b0; a1 = '0; b1 = '0; ordy1 = 1'b0;
        v0 = 1'b0; a0 = '0; b0 = '0; ordy0 = 1'b0;
        force0 = 1'b0;
        test_reset();
        test_equal_trace();
        test_greater();
        test_back_to_back();
        test_hold_result();
        test_reset_mid();
        test_comb_latency();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_compare_word_sequencer.md
Name: serial_compare_word_sequencer

Overview:
Sits around the MSB-first serial comparator. It accepts a pair of parallel WIDTH-bit words over a valid/ready handshake and clears the comparator. It then streams the word pair to the comparator one bit per cycle, most significant bit first. After the last bit it captures the comparator's less/eq/greater flags and returns them as one result over a valid/ready handshake. It processes one word pair at a time, with no overlap.

Parameters:
WIDTH, 8, bit width of each operand word (>= 2).
CMP_LATENCY, 1, cycles from a bit pair on ser_a/ser_b to its effect on cmp_* flags; legal values 0 (combinational comparator) and 1 (registered comparator).

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand pair available.
in_ready  output  1  block can accept an operand pair.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
ser_clear  output  1  one-cycle synchronous clear pulse to the comparator, ORed into its rst at top level.
ser_valid  output  1  ser_a/ser_b carry a live bit.
ser_a  output  1  current bit of A, MSB first.
ser_b  output  1  current bit of B, MSB first.
cmp_less  input  1  comparator a_less_b.
cmp_eq  input  1  comparator a_eq_b.
cmp_greater  input  1  comparator a_greater_b.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_less  output  1  captured A < B.
out_eq  output  1  captured A == B.
out_greater  output  1  captured A > B.
out_err  output  1  captured flags were not exactly one-hot.

Behaviour:
- FSM states: IDLE, CLEAR, SHIFT, WAIT, RESULT. All outputs come from registers or decode of state and registers only; no combinational path from an input to an output.
- Reset state: IDLE.
  - in_ready=1.
  - ser_clear, ser_valid, ser_a, ser_b = 0.
  - out_valid, out_less, out_eq, out_greater, out_err = 0.
  - Shift registers and bit counter = 0.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, load sh_a<=in_a and sh_b<=in_b, then go to CLEAR.
- CLEAR: exactly one cycle.
  - ser_clear=1, ser_valid=0.
  - Load counter<=WIDTH-1, then go to SHIFT.
- SHIFT: WIDTH cycles.
  - ser_valid=1, ser_a=sh_a[WIDTH-1], ser_b=sh_b[WIDTH-1].
  - Each cycle shift sh_a and sh_b left by one, zero fill, and decrement the counter.
  - On the counter==0 cycle with CMP_LATENCY=0: capture cmp_* into out_* in this cycle, then go to RESULT.
  - On the counter==0 cycle with CMP_LATENCY=1: go to WAIT.
- WAIT: CMP_LATENCY=1 only, one cycle.
  - ser_valid=0.
  - Capture cmp_* into out_*, then go to RESULT.
- Capture rule: out_err <= !(exactly one of cmp_less, cmp_eq, cmp_greater is 1). The flags are stored as seen, even when out_err=1.
- RESULT:
  - out_valid=1; out_less, out_eq, out_greater and out_err are held stable.
  - On out_ready, clear out_valid and go to IDLE. The flag outputs keep their value until the next capture.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored, and in_a/in_b are don't-care.
- Between frames, ser_a and ser_b are 0 whenever ser_valid=0.
- Latency, with the accept edge as cycle 0:
  - ser_clear is high in cycle 1.
  - Bits appear in cycles 2..WIDTH+1.
  - out_valid rises in cycle WIDTH+2 (CMP_LATENCY=0) or WIDTH+3 (CMP_LATENCY=1).
- Throughput: one pair per WIDTH+3+CMP_LATENCY cycles when out_ready is held high.
- Reset mid-operation: asserting rst forces the reset state immediately, asynchronously. Any in-flight word and any pending result are discarded.
- The first accept after rst deasserts behaves exactly like a first operation.

Test Plan:
1. WIDTH=8, CMP_LATENCY=1, registered comparator model; in_a=0xA5, in_b=0xA5 -> ser_a = ser_b = 1,0,1,0,0,1,0,1 in cycles 2..9; ser_clear high only in cycle 1; out_valid in cycle 11 with out_eq=1, out_less=0, out_greater=0, out_err=0.
2. in_a=0x80, in_b=0x7F -> first bit pair (1,0); result out_greater=1, out_eq=0, out_less=0.
3. in_a=0x00, in_b=0xFF -> result out_less=1. Back-to-back second pair 0x3C vs 0x3C with out_ready=1 is accepted in cycle 12 and returns out_eq=1; no stale flags are carried over from the first pair.
4. Hold out_ready=0 for 5 cycles in RESULT while toggling in_valid with new operands -> out_valid and flags stay stable, in_ready=0, nothing is accepted; after out_ready=1, in_ready=1 the next cycle.
5. Assert rst asynchronously in the 4th SHIFT cycle -> ser_valid=0, in_ready=1 and out_valid=0 with no clock edge; a subsequent 0x12 vs 0x34 completes with out_less=1.
6. CMP_LATENCY=0 instance with combinational model -> out_valid in cycle 10. Force cmp_less=1 and cmp_eq=1 in the capture cycle -> out_err=1 with both flags reported.
